// File: rtl/aes_pkg.sv
// AES shared types, constants and helpers for the key schedule and the encryptor datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    localparam int NR = 14;  // AES-256 rounds
    localparam int NK = 8;   // AES-256 key length in 32-bit words

    // Key-expansion FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } ks_state_e;

    // Round constants indexed by i = cnt/2 (entry 0 is never used by AES-256)
    localparam logic [0:7][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    // Cyclic left rotation by one byte: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes256_key_expand_if.sv
// Key-schedule control/read bus between the round-key generator and its user.
// Latency: n/a (wires only); rk_out is a combinational read of the key store.
// Backpressure: none; key_load is a single-cycle request accepted in any state.
// Signals: key_load/key_in (load request), busy/keys_valid (status),
//          rk_addr/rk_out (round-key read port), key_zeroize (only with AES_KEY_ZEROIZE_EN).
interface aes256_key_expand_if;
    import aes_pkg::*;

    logic           key_load;
    logic [255:0]   key_in;
    logic           busy;
    logic           keys_valid;
    logic [3:0]     rk_addr;
    block_t         rk_out;
`ifdef AES_KEY_ZEROIZE_EN
    logic           key_zeroize;

    modport master (
        output key_load, key_in, rk_addr, key_zeroize,
        input  busy, keys_valid, rk_out
    );

    modport slave (
        input  key_load, key_in, rk_addr, key_zeroize,
        output busy, keys_valid, rk_out
    );
`else
    modport master (
        output key_load, key_in, rk_addr,
        input  busy, keys_valid, rk_out
    );

    modport slave (
        input  key_load, key_in, rk_addr,
        output busy, keys_valid, rk_out
    );
`endif

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none.
// Ports: in_i (byte to substitute), out_o (substituted byte).
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    // Entry for input x sits at bits [2047-8x -: 8]
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] msb_idx;

    always_comb begin
        msb_idx = 11'd2047 - {in_i, 3'b000};
        out_o   = SBOX[msb_idx -: 8];
    end

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key expansion into a 15 x 128-bit round-key store, one round key per clock.
// Latency: keys_valid rises on the 13th edge after the edge that samples key_load.
// Backpressure: none; a new key_load restarts expansion immediately, discarding work in flight.
// Ports: clk, reset (sync, active-high), bus (slave side of aes256_key_expand_if).
// Option: AES_KEY_ZEROIZE_EN adds bus.key_zeroize, which clears the key store and wins over key_load.
module aes256_key_expand
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    aes256_key_expand_if.slave      bus
);

    ks_state_e  state_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       busy_q;
    logic       keys_valid_q;
    block_t     rk_q [0:NR];

    block_t     prev2;      // rk[cnt-2]
    word_t      t_word;     // last word of rk[cnt-1]
    word_t      sub_in;
    word_t      sub_out;
    word_t      temp;
    word_t      w0, w1, w2, w3;
    block_t     rk_d;       // round key written on the next EXPAND edge
    block_t     rd_data;

    // Operand fetch for the word being generated
    always_comb begin
        prev2  = '0;
        t_word = '0;
        for (int i = 0; i <= NR; i++) begin
            if (4'(i) == cnt_q - 4'd2) prev2  = rk_q[i];
            if (4'(i) == cnt_q - 4'd1) t_word = rk_q[i][31:0];
        end
    end

    // Even round keys start a new 8-word group (RotWord + Rcon); odd ones
    // sit at word offset 4 of the group, where AES-256 adds a bare SubWord.
    assign sub_in = cnt_q[0] ? t_word : rot_word(t_word);

    for (genvar g = 0; g < 4; g++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (sub_in[8*g +: 8]),
            .out_o (sub_out[8*g +: 8])
        );
    end

    always_comb begin
        temp  = sub_out;
        if (!cnt_q[0]) temp = sub_out ^ {RCON[cnt_q[3:1]], 24'h0};
        w0    = prev2[127:96] ^ temp;
        w1    = prev2[95:64]  ^ w0;
        w2    = prev2[63:32]  ^ w1;
        w3    = prev2[31:0]   ^ w2;
        rk_d  = {w0, w1, w2, w3};
        cnt_d = cnt_q + 4'd1;
    end

    // Single FSM process; busy/keys_valid are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end
`ifdef AES_KEY_ZEROIZE_EN
        else if (bus.key_zeroize) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            busy_q       <= 1'b0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
        end
`endif
        else if (bus.key_load) begin
            // Restart from any state; the in-flight write is suppressed
            rk_q[0]      <= bus.key_in[255:128];
            rk_q[1]      <= bus.key_in[127:0];
            cnt_q        <= 4'd2;
            state_q      <= ST_EXPAND;
            busy_q       <= 1'b1;
            keys_valid_q <= 1'b0;
        end
        else begin
            case (state_q)
                ST_EXPAND: begin
                    rk_q[cnt_q] <= rk_d;
                    if (cnt_q == 4'(NR)) begin
                        state_q      <= ST_DONE;
                        busy_q       <= 1'b0;
                        keys_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: ;  // IDLE and DONE hold until the next load
            endcase
        end
    end

    // Read port: plain mux, zero for addresses past the last round key
    always_comb begin
        rd_data = '0;
        for (int i = 0; i <= NR; i++) begin
            if (bus.rk_addr == 4'(i)) rd_data = rk_q[i];
        end
    end

    assign bus.rk_out     = rd_data;
    assign bus.busy       = busy_q;
    assign bus.keys_valid = keys_valid_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Self-checking bench for aes256_key_expand: known-answer table, random keys vs a
// FIPS-197 word-level model, latency, restart, mid-expansion reset and (optionally) zeroize.
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_aes256_key_expand;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    aes256_key_expand_if bus();

    aes256_key_expand dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_m [256];
    logic [127:0] exp_rk [15];

    typedef struct {
        logic [255:0] key;
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    vec_t vt [6];

    localparam logic [255:0] K0 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_w(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    // Textbook word-by-word schedule: 60 words, grouped four per round key
    task automatic model_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub_w(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++)
            exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_rk(input logic [3:0] a, output logic [127:0] d);
        bus.rk_addr = a;
        #1;
        d = bus.rk_out;
    endtask

    // Pulse key_load for one edge; keys_valid must already be low after that edge
    task automatic load_key(input logic [255:0] k, input string tag);
        bus.key_in   = k;
        bus.key_load = 1'b1;
        tick();
        bus.key_load = 1'b0;
        check({tag, "_kv_after_load"},   128'(bus.keys_valid), 128'd0);
        check({tag, "_busy_after_load"}, 128'(bus.busy),       128'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!bus.keys_valid && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.keys_valid) begin
            errors++;
            $display("FAIL %s_timeout: keys_valid still 0 after %0d cycles, required 1", tag, n);
        end
    endtask

    task automatic check_all(input string tag);
        logic [127:0] d;
        for (int a = 0; a < 15; a++) begin
            read_rk(4'(a), d);
            check($sformatf("%s_rk%0d", tag, a), d, exp_rk[a]);
        end
        read_rk(4'd15, d);
        check({tag, "_rk15_zero"}, d, 128'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] d;
        logic [255:0] ka, kb;

        build_sbox();

        reset        = 1'b1;
        bus.key_load = 1'b0;
        bus.key_in   = '0;
        bus.rk_addr  = 4'd0;
`ifdef AES_KEY_ZEROIZE_EN
        bus.key_zeroize = 1'b0;
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_kv",   128'(bus.keys_valid), 128'd0);
        read_rk(4'd0,  d); check("rst_rk0",  d, 128'd0);
        read_rk(4'd7,  d); check("rst_rk7",  d, 128'd0);
        read_rk(4'd14, d); check("rst_rk14", d, 128'd0);
        tick();
        check("idle_busy", 128'(bus.busy), 128'd0);

        // Latency: after the load edge S, busy for S..S+12, keys_valid from S+13
        load_key(K0, "lat");
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("lat_busy_e%0d", k), 128'(bus.busy),       128'(k < 13));
            check($sformatf("lat_kv_e%0d", k),   128'(bus.keys_valid), 128'(k >= 13));
        end
        tick();
        check("lat_kv_hold", 128'(bus.keys_valid), 128'd1);

        // Known-answer table (key, address, round key)
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        vt[0] = '{K0, 4'd0,  128'h000102030405060708090a0b0c0d0e0f};
        vt[1] = '{K0, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
        vt[2] = '{K0, 4'd2,  128'ha573c29fa176c498a97fce93a572c09c};
        vt[3] = '{K0, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
        vt[4] = '{K0, 4'd15, 128'h0};
        vt[5] = '{kb, 4'd15, 128'h0};
        for (int i = 0; i < 6; i++) begin
            load_key(vt[i].key, $sformatf("tab%0d", i));
            wait_valid($sformatf("tab%0d", i));
            read_rk(vt[i].addr, d);
            check($sformatf("tab%0d_rk%0d", i, vt[i].addr), d, vt[i].exp);
        end

        // Random keys against the model, including reload while in DONE
        for (int n = 0; n < 6; n++) begin
            ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            model_expand(ka);
            load_key(ka, $sformatf("rnd%0d", n));
            wait_valid($sformatf("rnd%0d", n));
            check_all($sformatf("rnd%0d", n));
        end

        // Restart: key B arrives while the A expansion is at cnt==7
        ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        kb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        load_key(ka, "rsA");
        for (int k = 0; k < 5; k++) tick();
        check("rs_midA_busy", 128'(bus.busy), 128'd1);
        load_key(kb, "rsB");
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("rs_kv_e%0d", k), 128'(bus.keys_valid), 128'd0);
        end
        tick();
        check("rs_kv_e13", 128'(bus.keys_valid), 128'd1);
        model_expand(kb);
        check_all("rsB");

        // Synchronous reset while expanding at cnt==9
        load_key(K0, "mr");
        for (int k = 0; k < 7; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mr_busy", 128'(bus.busy), 128'd0);
        check("mr_kv",   128'(bus.keys_valid), 128'd0);
        for (int a = 0; a < 16; a++) begin
            read_rk(4'(a), d);
            check($sformatf("mr_rk%0d_zero", a), d, 128'd0);
        end
        ka = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        model_expand(ka);
        load_key(ka, "mrl");
        wait_valid("mrl");
        check_all("mrl");

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize and load on the same edge: zeroize wins, nothing starts
        bus.key_in      = K0;
        bus.key_load    = 1'b1;
        bus.key_zeroize = 1'b1;
        tick();
        bus.key_load    = 1'b0;
        bus.key_zeroize = 1'b0;
        check("zz_kv",   128'(bus.keys_valid), 128'd0);
        check("zz_busy", 128'(bus.busy), 128'd0);
        for (int a = 0; a < 15; a++) begin
            read_rk(4'(a), d);
            check($sformatf("zz_rk%0d", a), d, 128'd0);
        end
        for (int k = 0; k < 15; k++) tick();
        check("zz_idle_busy", 128'(bus.busy), 128'd0);
        check("zz_idle_kv",   128'(bus.keys_valid), 128'd0);
        read_rk(4'd2, d);
        check("zz_idle_rk2", d, 128'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation time limit reached, required earlier finish");
        $fatal(1);
    end

endmodule
